// File: rtl/led_status_ctrl.sv
// LED status controller: turns a controller FSM state code into an LED
// display (one-hot, binary, bar graph or blank). A transition flash shows
// all display LEDs lit for a short time after each state change. The error
// state blinks its pattern. The top LED holds a sticky error flag until the
// error is acknowledged.
module led_status_ctrl #(
  parameter int unsigned N_LEDS     = 8,
  parameter int unsigned STATE_W    = 4,
  parameter int unsigned ERR_STATE  = 6,
  parameter int unsigned BLINK_HALF = 12_500_000,
  parameter int unsigned FLASH_CYC  = 2_500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  input  logic [1:0]         mode,
  input  logic               err_clr,
  output logic [N_LEDS-1:0]  leds,
  output logic               err_sticky
);

  // Display field width: every LED except the top one, which shows the sticky error.
  localparam int unsigned L       = N_LEDS - 1;
  localparam int unsigned BLINK_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned FLASH_W = $clog2(FLASH_CYC + 1);

  localparam logic [1:0] MODE_ONEHOT = 2'd0;
  localparam logic [1:0] MODE_BINARY = 2'd1;
  localparam logic [1:0] MODE_BAR    = 2'd2;
  localparam logic [1:0] MODE_BLANK  = 2'd3;

  // Reject parameter values outside their legal ranges at elaboration time.
  if (N_LEDS < 4 || N_LEDS > 16) begin : g_bad_nleds
    $error("led_status_ctrl: N_LEDS must be 4..16");
  end
  if (BLINK_HALF < 2) begin : g_bad_blink
    $error("led_status_ctrl: BLINK_HALF must be >= 2");
  end
  if (FLASH_CYC < 1) begin : g_bad_flash
    $error("led_status_ctrl: FLASH_CYC must be >= 1");
  end

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] prev_q;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               err_q, err_d;
  logic [N_LEDS-1:0]  leds_q, leds_d;

  logic               in_err_c;
  logic               trans_c;
  logic [L-1:0]       base_c;
  logic [L-1:0]       field_c;

  assign in_err_c = (state_q == STATE_W'(ERR_STATE));
  assign trans_c  = (state_q != prev_q);

  // Free-running blink timebase; phase toggles at every wrap.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Flash counter: reload on a state change, otherwise count down to zero and stay there.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (trans_c) begin
      flash_cnt_d = FLASH_W'(FLASH_CYC);
    end else if (flash_cnt_q != '0) begin
      flash_cnt_d = flash_cnt_q - FLASH_W'(1);
    end
  end

  // Sticky error: set while in the error state, cleared on request otherwise.
  always_comb begin
    err_d = err_q;
    if (in_err_c) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Base display pattern from the registered state and the current mode.
  always_comb begin
    int st;
    st     = int'(state_q);
    base_c = '0;
    case (mode)
      MODE_ONEHOT: begin
        for (int i = 0; i < int'(L); i++) begin
          base_c[i] = (st == i);
        end
      end
      MODE_BINARY: begin
        base_c = L'(state_q);
      end
      MODE_BAR: begin
        for (int i = 0; i < int'(L); i++) begin
          base_c[i] = (st > i);
        end
      end
      MODE_BLANK: begin
        base_c = '0;
      end
      default: begin
        base_c = '0;
      end
    endcase
  end

  // Display field priority: error blink, then transition flash, then base pattern.
  // The flash decision uses the counter's next value so a flash spans exactly
  // FLASH_CYC LED updates starting with the first update after the change.
  always_comb begin
    field_c = base_c;
    if (in_err_c) begin
      field_c = base_c & {L{blink_phase_q}};
    end else if (flash_cnt_d != '0) begin
      field_c = '1;
    end
    leds_d = {err_d, field_c};
  end

  // State, timers, sticky error and LED drive registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= '0;
      prev_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      flash_cnt_q   <= '0;
      err_q         <= 1'b0;
      leds_q        <= '0;
    end else begin
      state_q       <= state;
      prev_q        <= state_q;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      flash_cnt_q   <= flash_cnt_d;
      err_q         <= err_d;
      leds_q        <= leds_d;
    end
  end

  assign leds       = leds_q;
  assign err_sticky = err_q;

endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 Parameter N_LEDS, default 8, number of LED outputs (legal 4..16); bit N_LEDS-1 is reserved for sticky error.
REQ-002 Parameter STATE_W, default 4, width of the FSM state code.
REQ-003 Parameter ERR_STATE, default 6, state code treated as the system error state.
REQ-004 Parameter BLINK_HALF, default 12_500_000, clock cycles per blink half-period (legal >= 2).
REQ-005 Parameter FLASH_CYC, default 2_500_000, clock cycles of transition flash (legal >= 1).
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 state  input  STATE_W  FSM state code from the controller.
REQ-009 mode  input  2  display mode: 0 one-hot, 1 binary, 2 bar graph, 3 blank.
REQ-010 err_clr  input  1  level request to clear the sticky error indicator.
REQ-011 leds  output  N_LEDS  registered LED drive, 1 = lit.
REQ-012 err_sticky  output  1  registered latched-error flag, mirrored on leds[N_LEDS-1].

Function
REQ-013 state SHALL be registered into state_q every cycle; leds SHALL be computed from state_q and registered, giving 2-cycle latency from a state input change to leds.
REQ-014 Let L = N_LEDS-1 (display field leds[L-1:0]); base pattern from state_q and current mode:
- mode 0: bit state_q set if state_q < L, else all zero.
- mode 1: state_q zero-extended or truncated to L bits.
- mode 2: lowest min(state_q, L) bits set; state_q=0 gives all zero; saturates at all ones.
- mode 3: all zero.
REQ-015 Blink counter SHALL count 0..BLINK_HALF-1 continuously, wrapping to 0; blink_phase SHALL toggle on each wrap.
REQ-016 While state_q == ERR_STATE, the display field SHALL equal base AND blink_phase (replicated); flash SHALL be suppressed.
REQ-017 Transition detect: when state_q differs from its previous-cycle value, flash counter SHALL load FLASH_CYC; otherwise decrement to 0 and stick.
REQ-018 While flash counter != 0 and state_q != ERR_STATE, the display field SHALL be all ones.
REQ-019 A new transition while flash is active SHALL reload FLASH_CYC (no accumulation).
REQ-020 A mode change alone SHALL NOT trigger flash; new mode takes effect on the next leds update.
REQ-021 err_sticky SHALL set on any cycle where state_q == ERR_STATE; SHALL clear on a cycle where err_clr=1 and state_q != ERR_STATE; set wins when both apply.
REQ-022 leds[N_LEDS-1] SHALL equal err_sticky (registered together), never blink or flash, and is shown in all modes including mode 3.
REQ-023 Priority for display field: error blink > flash > base pattern.
REQ-024 state codes >= 2^STATE_W cannot occur; codes outside the mode mapping SHALL produce zero (mode 0) without error.

Reset
REQ-025 While rst=1, leds=0, err_sticky=0, state_q=0, previous state=0, blink counter=0, blink_phase=1, flash counter=0, asynchronously.
REQ-026 Reset release SHALL NOT itself trigger flash; first transition is counted only after a post-reset change of state.
REQ-027 rst asserted mid-flash or mid-blink SHALL abort immediately; outputs resume per REQ-013 after release.

Verification (N_LEDS=8, STATE_W=4, ERR_STATE=6, BLINK_HALF=4, FLASH_CYC=3)
REQ-028 Reset, mode=0, state held 0 -> leds=8'h01 from second edge after release; no flash.
REQ-029 mode=0, state 0->2 -> leds=8'h7F for 3 cycles then 8'h04; change to 3 during flash -> flash reloads to 3 more cycles, then 8'h08.
REQ-030 mode=2, state=5 steady -> leds=8'h1F; mode=1, state=5 -> 8'h05; mode=3 -> 8'h00; mode changes never flash.
REQ-031 mode=0, state=6 -> leds[7]=1 constant, leds[6] alternates 4 cycles on / 4 off, no flash; err_clr=1 while in state 6 -> err_sticky stays 1.
REQ-032 After error, state 6->1, err_clr pulse 1 cycle -> err_sticky=0 next edge; leds=8'h02 after flash ends; mode=3 during error -> leds=8'h80.
REQ-033 rst pulse asserted mid-flash with err_sticky=1 -> leds=0 and err_sticky=0 immediately, before next clk edge.
